// File: rtl/fetch_queue.sv
// fetch_queue: {pc, instr} FIFO between fetch and decode; first-word-fall-through head with no empty bypass (1-cycle latency).
// Backpressure: in_ready drops only when full (no path from out_ready); flush/rst discard all entries and same-cycle traffic.
module fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int PC_W    = 12,
  parameter int INSTR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  logic   w_clear;
  entry_t w_head;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_clear = rst || flush;
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign count     = r_count;

  // Head is masked to zero when empty so decode never sees stale array data.
  assign w_head    = r_mem[r_rd_ptr];
  assign out_pc    = w_empty ? '0 : w_head.pc;
  assign out_instr = w_empty ? '0 : w_head.instr;

  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue tracks accepted entries, a negedge monitor compares the DUT head.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [11:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [3:0]  count;

  fetch_queue #(.DEPTH(8), .PC_W(12), .INSTR_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          mcnt = 0;
  int          n_pops = 0;
  logic [11:0] last_pc = '0;
  bit          started = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: updates on the same edge as the DUT.
  always @(posedge clk) begin
    started = 1;
    if (rst || flush) begin
      sb.delete();
      mcnt = 0;
    end else begin
      bit p, q;
      p = in_valid && (mcnt != 8);
      q = (mcnt != 0) && out_ready;
      if (q) begin
        last_pc = sb[0].pc;
        void'(sb.pop_front());
        n_pops++;
      end
      if (p) sb.push_back('{pc: in_pc, instr: in_instr});
      mcnt = mcnt + (p ? 1 : 0) - (q ? 1 : 0);
    end
  end

  // Monitor: compares DUT state and head against the scoreboard mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(mcnt));
      chk("in_ready", 32'(in_ready), 32'(mcnt != 8));
      chk("out_valid", 32'(out_valid), 32'(mcnt != 0));
      if (out_valid && sb.size() > 0) begin
        chk("head_pc", 32'(out_pc), 32'(sb[0].pc));
        chk("head_instr", out_instr, sb[0].instr);
      end else if (!out_valid) begin
        chk("idle_pc", 32'(out_pc), 32'h0);
        chk("idle_instr", out_instr, 32'h0);
      end
    end
  end

  task automatic cyc(input logic v, input logic [11:0] pc, input logic ordy,
                     input logic fl = 1'b0, input logic r = 1'b0);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = 32'h1000_0000 + 32'(pc);
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) cyc(1'b0, 12'h0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;

    // Reset held two cycles with in_valid high.
    cyc(1'b1, 12'h004, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 12'h008, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 12'h000, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill and backpressure.
    for (int i = 0; i < 8; i++) cyc(1'b1, 12'(i*4), 1'b0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 12'd32, 1'b0);
    chk("ninth_ignored", 32'(count), 32'd8);
    n_pops = 0;
    drain();
    chk("drain_pops", 32'(n_pops), 32'd8);
    chk("drain_last_pc", 32'(last_pc), 32'd28);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Latency: entry not visible in the push cycle.
    in_valid = 1'b1; in_pc = 12'h040; in_instr = 32'h1000_0040; out_ready = 1'b1;
    #3;
    chk("lat_same_cycle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_next_valid", 32'(out_valid), 32'd1);
    chk("lat_next_pc", 32'(out_pc), 32'h040);
    drain();

    // Streaming with both sides ready, then toggling out_ready across wrap.
    for (int i = 0; i < 20; i++) cyc(1'b1, 12'(12'h200 + i*4), 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b1, 12'(12'h300 + i*4), 1'(i % 2));
    for (int i = 0; i < 10; i++) cyc(1'b1, 12'(12'h400 + i*4), 1'b0);
    chk("stream_full", 32'(count), 32'd8);
    in_valid = 1'b1; in_pc = 12'h500; in_instr = 32'h1000_0500; out_ready = 1'b1;
    #3;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("full_pop_count", 32'(count), 32'd7);
    drain();

    // Flush mid-stream with same-cycle push and pop.
    for (int i = 0; i < 5; i++) cyc(1'b1, 12'(12'h600 + i*4), 1'b0);
    chk("pre_flush_count", 32'(count), 32'd5);
    cyc(1'b1, 12'h0AA, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 12'h100, 1'b0);
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_pc", 32'(out_pc), 32'h100);
    chk("post_flush_instr", out_instr, 32'h1000_0100);
    drain();

    // Reset and flush together with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 12'(12'h700 + i*4), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    cyc(1'b1, 12'h7F0, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_pc", 32'(out_pc), 32'd0);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 12'h124, 1'b0);
    chk("after_rst_pc", 32'(out_pc), 32'h124);
    n_pops = 0;
    cyc(1'b0, 12'h0, 1'b1);
    chk("after_rst_pop", 32'(n_pops), 32'd1);
    chk("after_rst_last", 32'(last_pc), 32'h124);
    chk("after_rst_empty", 32'(out_valid), 32'd0);

    cyc(1'b0, 12'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the fetch stage (PC / instruction ROM / fetch buffer) and decode. Holds `{pc, instr}` pairs produced each cycle by fetch and presents them in program order to decode with a valid/ready handshake. Absorbs decode stalls and drops all in-flight entries on a pipeline flush (branch mispredict / exception redirect).

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `PC_W`, 12, PC width (matches the 12-bit fetch PC)
- `INSTR_W`, 32, instruction width

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all entries
- `in_valid`  in  1  fetch presents an entry
- `in_pc`  in  PC_W  PC of the incoming instruction
- `in_instr`  in  INSTR_W  incoming instruction word
- `in_ready`  out  1  queue can accept an entry this cycle
- `out_valid`  out  1  head entry available to decode
- `out_pc`  out  PC_W  PC of the head entry
- `out_instr`  out  INSTR_W  instruction of the head entry
- `out_ready`  in  1  decode consumes the head this cycle
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry array of `{pc, instr}`; write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter `count`.
- `in_ready = (count != DEPTH)`. Depends only on registered state; no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- Push = `in_valid && in_ready`: write entry at `wr_ptr`, `wr_ptr <= wr_ptr + 1`.
- Pop = `out_valid && out_ready`: `rd_ptr <= rd_ptr + 1`.
- Count: push only → +1; pop only → −1; push and pop → unchanged.
- Head is first-word-fall-through: `out_pc`/`out_instr` driven from array entry at `rd_ptr` when `out_valid=1`; forced to 0 when `out_valid=0`.
- No empty bypass: an entry pushed in cycle N is visible at the output no earlier than cycle N+1.
- Full: `in_ready=0` even if a pop occurs in the same cycle; `in_valid` is ignored. Fetch must hold its entry.
- Empty: `out_ready` is ignored; pointers and count unchanged.
- Flush (`flush=1` and `rst=0`): `wr_ptr`, `rd_ptr`, `count` ← 0; any same-cycle push or pop is discarded. Array contents need not be cleared.
- Reset (`rst=1`): same as flush; `rst` has priority over everything else, including when asserted mid-stream.
- Entries leave in exactly the order they were accepted; PC and instruction stay paired.

## Timing
- Reset values, in the cycle after `rst` is sampled high: `count=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, `in_ready=1`.
- Latency: push at edge N → `out_valid=1` with that entry after edge N (cycle N+1) when the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- After flush at edge N: `out_valid=0`, `in_ready=1` in cycle N+1; a push in cycle N+1 is accepted normally.
- All outputs are functions of registered state only (array, pointers, count).

## Test plan
- Reset: hold `rst=1` for 2 cycles with `in_valid=1` → `count=0`, `out_valid=0`, `out_pc=0`, `out_instr=0`, `in_ready=1`; nothing is enqueued.
- Fill / backpressure: `out_ready=0`, push PCs 0,4,…,28 with instr = 0x1000_0000+PC → `count=8`, `in_ready=0`; a 9th push with PC=32 is ignored; drain shows PCs 0..28 in order with matching instructions, then `out_valid=0`.
- Latency / no bypass: empty queue, push PC=0x040 at edge N with `out_ready=1` → `out_valid=0` in cycle N, `out_pc=0x040` with `out_valid=1` in cycle N+1.
- Simultaneous push/pop and wrap-around: stream 20 entries with both sides ready every cycle, then with `out_ready` toggling each cycle → order preserved across pointer wrap; `count` never exceeds 8; at full with `out_ready=1`, `in_ready=0` and count drops to 7 next cycle.
- Flush mid-stream: 5 entries queued, assert `flush` together with `in_valid=1` and `out_ready=1` → next cycle `count=0`, `out_valid=0`, and the same-cycle push is not present; a push with PC=0x100 the following cycle appears at the head.
- Reset mid-operation: `rst` and `flush` asserted together with the queue at 3 entries → identical to the reset values; a subsequent push/pop of a single entry behaves normally.
